// File: rtl/dram_responder_pkg.sv
// Shared constants for the memory-side DRAM responder: store encodings, FSM states, lane widths.
// Unlisted store_conf encodings are treated as no-op writes by the responder.
package dram_responder_pkg;

   typedef enum logic [1:0] {
      sb_conf = 2'b00,
      sh_conf = 2'b01,
      sw_conf = 2'b10
   } store_conf;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } dram_resp_state_t;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous RAM, DEPTH x DATA_SIZE: one read or one write per cycle, read data registered.
// Never stalls; a write in the same cycle as a read request takes the port and leaves rdata unchanged.
module dram_array #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 512
) (
   input  logic                 clk,
   input  logic                 re,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_SIZE-1:0] wdata,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [DATA_SIZE-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Memory-side end of the core/DRAM link: reads return in 1 cycle, sw writes in 1, sb/sh take a 2-cycle RMW.
// dram_ready drops for the single MERGE cycle of a sub-word store and while rst is high.
module dram_responder
   import dram_responder_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dram_re,
   input  logic                 dram_we,
   input  logic [ADDR_W-1:0]    dram_address,
   input  logic [DATA_SIZE-1:0] dram_datain,
   input  logic [1:0]           store_type,
   output logic [DATA_SIZE-1:0] dmem_word,
   output logic                 dram_rvalid,
   output logic                 dram_ready
);

   dram_resp_state_t     state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [HALF_W-1:0]    data_q, data_d;
   logic                 half_q, half_d;
   logic                 rvalid_q, rvalid_d;
   logic [DATA_SIZE-1:0] last_q, last_d;

   logic                 arr_re, arr_we;
   logic [ADDR_W-1:0]    arr_addr;
   logic [DATA_SIZE-1:0] arr_wdata, arr_rdata, merged;

   dram_array #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH)
   ) u_array (
      .clk   (clk),
      .re    (arr_re),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      half_d     = half_q;
      rvalid_d   = 1'b0;
      last_d     = rvalid_q ? arr_rdata : last_q;
      arr_re     = 1'b0;
      arr_we     = 1'b0;
      arr_addr   = dram_address;
      arr_wdata  = dram_datain;
      dram_ready = (state_q == IDLE) && !rst;

      // The array's read register still holds the old word fetched when the store was accepted.
      merged = arr_rdata;
      if (half_q) begin
         merged[HALF_W-1:0] = data_q;
      end else begin
         merged[BYTE_W-1:0] = data_q[BYTE_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (dram_ready && dram_we) begin
               case (store_type)
                  sw_conf: arr_we = 1'b1;
                  sb_conf, sh_conf: begin
                     arr_re  = 1'b1;
                     addr_d  = dram_address;
                     data_d  = dram_datain[HALF_W-1:0];
                     half_d  = (store_type == sh_conf);
                     state_d = MERGE;
                  end
                  default: ;
               endcase
            end else if (dram_ready && dram_re) begin
               arr_re   = 1'b1;
               rvalid_d = 1'b1;
            end
         end
         MERGE: begin
            arr_addr  = addr_q;
            arr_wdata = merged;
            arr_we    = !rst;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         half_q   <= 1'b0;
         rvalid_q <= 1'b0;
         last_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         half_q   <= half_d;
         rvalid_q <= rvalid_d;
         last_q   <= last_d;
      end
   end

   assign dram_rvalid = rvalid_q;
   assign dmem_word   = rvalid_q ? arr_rdata : last_q;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: transaction-level memory model checked every cycle, plus directed literal checks.
module tb_dram_responder;
   import dram_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dram_re, dram_we;
   logic [8:0]  dram_address;
   logic [31:0] dram_datain;
   logic [1:0]  store_type;
   logic [31:0] dmem_word;
   logic        dram_rvalid, dram_ready;

   dram_responder #(.DATA_SIZE(32), .ADDR_W(9), .DEPTH(512)) dut (
      .clk          (clk),
      .rst          (rst),
      .dram_re      (dram_re),
      .dram_we      (dram_we),
      .dram_address (dram_address),
      .dram_datain  (dram_datain),
      .store_type   (store_type),
      .dmem_word    (dmem_word),
      .dram_rvalid  (dram_rvalid),
      .dram_ready   (dram_ready)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: a plain word array plus one pending sub-word store.
   logic [31:0] m_mem [512];
   bit          m_busy   = 1'b0;
   logic [8:0]  m_pa;
   logic [31:0] m_pd;
   bit          m_ph;
   bit          m_rvalid = 1'b0;
   logic [31:0] m_word   = 32'h0;
   bit          chk_en   = 1'b0;

   logic        log_rdy  [4096];
   logic        log_rv   [4096];
   logic [31:0] log_word [4096];
   logic [31:0] pre      [64];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         m_busy   = 1'b0;
         m_rvalid = 1'b0;
         m_word   = 32'h0;
         chk_en   = 1'b1;
      end else if (m_busy) begin
         if (m_ph) m_mem[m_pa] = (m_mem[m_pa] & 32'hFFFF_0000) | (m_pd & 32'h0000_FFFF);
         else      m_mem[m_pa] = (m_mem[m_pa] & 32'hFFFF_FF00) | (m_pd & 32'h0000_00FF);
         m_busy   = 1'b0;
         m_rvalid = 1'b0;
      end else if (dram_we) begin
         m_rvalid = 1'b0;
         if (store_type == sw_conf) begin
            m_mem[dram_address] = dram_datain;
         end else if (store_type == sb_conf || store_type == sh_conf) begin
            m_busy = 1'b1;
            m_pa   = dram_address;
            m_pd   = dram_datain;
            m_ph   = (store_type == sh_conf);
         end
      end else if (dram_re) begin
         m_rvalid = 1'b1;
         m_word   = m_mem[dram_address];
      end else begin
         m_rvalid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cyc < 4096) begin
         log_rdy[cyc]  = dram_ready;
         log_rv[cyc]   = dram_rvalid;
         log_word[cyc] = dmem_word;
      end
      if (chk_en) begin
         check("ready", {31'b0, dram_ready}, {31'b0, !m_busy && !rst});
         check("rvalid", {31'b0, dram_rvalid}, {31'b0, m_rvalid});
         check("dmem_word", dmem_word, m_word);
      end
   end

   // Holds the request until the DUT shows ready before an edge; returns the accepting edge number.
   task automatic req(input logic re, input logic we, input logic [8:0] a,
                      input logic [31:0] d, input logic [1:0] st, output int e);
      int   n;
      logic rdy;
      dram_re = re; dram_we = we; dram_address = a; dram_datain = d; store_type = st;
      n = 0;
      do begin
         @(negedge clk);
         rdy = dram_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 20);
      if (!rdy) check("req_timeout", 32'd0, 32'd1);
      e = cyc;
      dram_re = 1'b0;
      dram_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int e, e1, e2, e3, k;
      logic re, we;
      logic [1:0] st;
      rst = 1'b1; dram_re = 1'b0; dram_we = 1'b0;
      dram_address = '0; dram_datain = '0; store_type = sw_conf;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_ready", {31'b0, log_rdy[2]}, 32'd0);
      check("rst_rvalid", {31'b0, log_rv[2]}, 32'd0);
      check("rst_word", log_word[2], 32'd0);
      check("ready_after_rst", {31'b0, log_rdy[3]}, 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 64; i++) begin
         pre[i] = $urandom;
         if (i == 1) pre[i] = 32'd1;
         if (i == 2) pre[i] = 32'd2;
         if (i == 3) pre[i] = 32'd3;
         if (i == 16) pre[i] = 32'h1122_3344;
         if (i == 32) pre[i] = 32'hFFFF_FFFF;
         req(1'b0, 1'b1, 9'(i), pre[i], sw_conf, e);
      end

      req(1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, sw_conf, e1);
      req(1'b1, 1'b0, 9'h005, 32'h0, sw_conf, e2);
      idle(2);
      check("sw_then_read_gap", 32'(e2 - e1), 32'd1);
      check("sw_ready_held", {31'b0, log_rdy[e1]}, 32'd1);
      check("sw_read_word", log_word[e2], 32'hDEAD_BEEF);
      check("sw_read_rvalid", {31'b0, log_rv[e2]}, 32'd1);

      req(1'b0, 1'b1, 9'h010, 32'h0000_00AA, sb_conf, e1);
      req(1'b1, 1'b0, 9'h010, 32'h0, sw_conf, e2);
      idle(2);
      check("sb_ready_low", {31'b0, log_rdy[e1]}, 32'd0);
      check("sb_ready_back", {31'b0, log_rdy[e1 + 1]}, 32'd1);
      check("sb_read_gap", 32'(e2 - e1), 32'd2);
      check("sb_merge", log_word[e2], 32'h1122_33AA);
      req(1'b0, 1'b1, 9'h010, 32'h0000_BEEF, sh_conf, e1);
      req(1'b1, 1'b0, 9'h010, 32'h0, sw_conf, e2);
      idle(2);
      check("sh_merge", log_word[e2], 32'h1122_BEEF);

      req(1'b1, 1'b0, 9'h001, 32'h0, sw_conf, e1);
      req(1'b1, 1'b0, 9'h002, 32'h0, sw_conf, e2);
      req(1'b1, 1'b0, 9'h003, 32'h0, sw_conf, e3);
      idle(2);
      check("b2b_gap", 32'(e3 - e1), 32'd2);
      check("b2b_word1", log_word[e1], 32'd1);
      check("b2b_word2", log_word[e1 + 1], 32'd2);
      check("b2b_word3", log_word[e1 + 2], 32'd3);
      check("b2b_rvalid", {31'b0, log_rv[e1] & log_rv[e1 + 1] & log_rv[e1 + 2]}, 32'd1);

      req(1'b0, 1'b1, 9'h030, 32'h0000_0055, sb_conf, e1);
      req(1'b0, 1'b1, 9'h031, 32'h1234_5678, sw_conf, e2);
      check("sw_held_in_merge", 32'(e2 - e1), 32'd2);
      req(1'b1, 1'b0, 9'h030, 32'h0, sw_conf, e1);
      req(1'b1, 1'b0, 9'h031, 32'h0, sw_conf, e2);
      idle(2);
      check("sb_word_after_hold", log_word[e1], {pre[48][31:8], 8'h55});
      check("sw_word_after_hold", log_word[e2], 32'h1234_5678);

      req(1'b0, 1'b1, 9'h020, 32'h0000_0077, sb_conf, e1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req(1'b1, 1'b0, 9'h020, 32'h0, sw_conf, e2);
      idle(2);
      check("rst_in_merge_ready", {31'b0, log_rdy[e1]}, 32'd0);
      check("rst_discards_merge", log_word[e2], 32'hFFFF_FFFF);

      req(1'b1, 1'b1, 9'h021, 32'hCAFE_F00D, sw_conf, e1);
      req(1'b1, 1'b0, 9'h021, 32'h0, sw_conf, e2);
      idle(2);
      check("re_we_no_rvalid", {31'b0, log_rv[e1]}, 32'd0);
      check("re_we_write_wins", log_word[e2], 32'hCAFE_F00D);

      req(1'b0, 1'b1, 9'h022, 32'h0BAD_BEEF, 2'b11, e1);
      req(1'b1, 1'b0, 9'h022, 32'h0, sw_conf, e2);
      idle(2);
      check("bad_type_ready", {31'b0, log_rdy[e1]}, 32'd1);
      check("bad_type_noop", log_word[e2], pre[34]);

      for (int i = 0; i < 1500; i++) begin
         k = $urandom_range(0, 9);
         re = (k < 4) || (k >= 8);
         we = (k >= 4);
         k = $urandom_range(0, 9);
         st = (k < 3) ? sb_conf : (k < 6) ? sh_conf : (k < 9) ? sw_conf : 2'b11;
         req(re, we, 9'($urandom_range(0, 63)), $urandom, st, e);
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side end of the core-to-DRAM interface. It owns the 512-word data RAM array and answers the dram_re, dram_we, dram_address and dram_datain strobes produced by the core's DRAM controller.
- Returns read words on dmem_word with one-cycle latency.
- Performs sub-word stores (sb/sh) as a two-cycle read-modify-write that merges into the low lane(s) of the addressed word. It back-pressures the controller with dram_ready while the merge is in flight.

Parameters:
DATA_SIZE, 32, word width in bits (equals `data_size)
ADDR_W, 9, word-address width
DEPTH, 512, number of words; must equal 2**ADDR_W

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  reset, synchronous, active-high
dram_re  in  1  read request
dram_we  in  1  write request
dram_address  in  ADDR_W  word address
dram_datain  in  DATA_SIZE  write data; sub-word data is right-justified in bits [7:0] or [15:0]
store_type  in  store_conf  sb_conf, sh_conf or sw_conf; sampled only when dram_we=1
dmem_word  out  DATA_SIZE  registered read data
dram_rvalid  out  1  dmem_word updated this cycle by a read
dram_ready  out  1  responder accepts a request this cycle

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; dram_ready=0 while rst is high, 1 in the first cycle after rst falls.
  - dram_rvalid=0, dmem_word=0.
  - Array contents are not reset.
- A request is accepted when dram_ready=1 and (dram_re or dram_we) at a rising edge. Requests while dram_ready=0 are ignored; the controller must hold them.
- Read accepted at edge N:
  - dmem_word = array[addr] and dram_rvalid=1 during cycle N+1.
  - dram_rvalid drops the next cycle unless another read is accepted.
  - dmem_word holds its last read value until the next read completes.
  - Back-to-back reads run at one per cycle.
- sw accepted at edge N: array[addr] = dram_datain written at edge N. dram_ready stays 1, so a read of the same address accepted at N+1 returns the new word.
- sb/sh accepted at edge N, read-modify-write:
  - Edge N: array read of addr; address, data and type latched; state goes IDLE to MERGE.
  - Cycle N+1: dram_ready=0.
  - Edge N+1: write of merged = old with [7:0] (sb) or [15:0] (sh) replaced by the latched data, upper bits preserved; state goes MERGE to IDLE.
  - Cycle N+2: dram_ready=1 again.
  - A merge does not touch dmem_word or dram_rvalid.
- dram_re and dram_we both high: the write wins, the read is dropped and dram_rvalid stays 0.
- Unknown store_type encoding with dram_we=1: no array write, no state change (no-op).
- Address is a word index; no wrap logic is needed since ADDR_W fully decodes DEPTH.
- Reset during MERGE: the pending merge is discarded, the array word keeps its old value, and the FSM returns to IDLE.
- FSM states:
  - IDLE: go to MERGE on an accepted sb/sh; otherwise stay.
  - MERGE: always go to IDLE.

Decomposition:
- Add to the shared constants package:
  - typedef dram_resp_state_t {IDLE, MERGE};
  - byte/half lane widths (8, 16).
- Reuse the existing store_conf enum.
- One sub-module, dram_array:
  - single-port synchronous RAM, DEPTH x DATA_SIZE;
  - one read or one write per cycle; registered read data; no reset.
- The FSM, merge mux and output registers live in dram_responder.

Test Plan:
- Reset with rst=1 for 3 cycles, then release -> dram_ready=0, dram_rvalid=0, dmem_word=0 during reset; dram_ready=1 in the first cycle after release.
- sw addr 0x005 data 0xDEADBEEF at edge N, then read 0x005 at N+1 -> dmem_word=0xDEADBEEF and dram_rvalid=1 in cycle N+2; dram_ready never drops.
- Word 0x010 = 0x11223344, then sb 0x010 data 0x000000AA -> dram_ready=0 for exactly one cycle; a later read returns 0x112233AA. Then sh data 0x0000BEEF -> read returns 0x1122BEEF.
- Reads of 0x001, 0x002 and 0x003 on consecutive cycles (preloaded 1, 2, 3) -> dmem_word 1, 2, 3 on consecutive cycles with dram_rvalid held high.
- sb accepted, then a sw to another address held during the MERGE cycle -> the sw is ignored during MERGE and accepted the next cycle; both words are correct afterwards.
- sb to 0x020 (old 0xFFFFFFFF) with rst=1 asserted in the MERGE cycle -> after reset, a read of 0x020 returns 0xFFFFFFFF. Separately, re=we=1 -> write occurs and dram_rvalid stays 0.
